guess_entry: RTL
================

# guess_entry

Upstream guess-commit stage for the hangman game, feeding the guess input of `control_unit`. It debounces the active-low commit key and latches the 6-bit letter code on the switches at the moment of a press. It classifies the guess as out-of-alphabet, duplicate, or new, and forwards only new letters with a one-cycle strobe. `control_unit` then sees one clean, held guess per press instead of live switch values.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples required to change the debounced key level (10 ms at 50 MHz).
- `LETTER_MIN`, default 6'hA: code of letter A.
- `LETTER_MAX`, default 6'h23: code of letter Z.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `key_n`  in  1  raw commit push-button, active-low, asynchronous to `clk`.
- `sw_letter`  in  6  raw letter code from SW[5:0].
- `game_over`  in  1  high while the game is in LOSE or WIN; freezes entry.
- `guess_out`  out  6  last accepted letter code, held until the next acceptance.
- `guess_valid`  out  1  one-cycle strobe: `guess_out` updated with a new letter.
- `dup_flag`  out  1  one-cycle strobe: the letter was already accepted earlier.
- `bad_flag`  out  1  one-cycle strobe: the code is outside `LETTER_MIN`..`LETTER_MAX`.
- `guesses_made`  out  5  count of accepted letters, saturating at 26.

## Operation
- **Synchroniser:** `key_n` passes through a 2-flop synchroniser.
- **Debouncer:**
  - The counter restarts whenever the synchronised sample equals the debounced level.
  - The debounced level flips when `DEBOUNCE_CYCLES` consecutive samples differ from it.
  - Debounced level resets to 1 (released).
- **Press:** a debounced 1->0 transition.
- **FSM states:** IDLE, CHECK, ISSUE, WAIT_RELEASE. Reset state is WAIT_RELEASE.
  - IDLE: on a press with `game_over`=0, capture `sw_letter` into `cap` and go to CHECK. A press with `game_over`=1 is ignored and goes to WAIT_RELEASE.
  - CHECK: classify `cap`, in priority order bad, then dup, then new. Register the result. Go to ISSUE.
  - ISSUE: assert exactly one strobe for this cycle.
    - For new: load `guess_out`<=`cap`, set the `used` bit (`cap`-`LETTER_MIN`), and increment `guesses_made` (saturating at 26).
    - Go to WAIT_RELEASE.
  - WAIT_RELEASE: go to IDLE when the debounced level is 1.
- **`used` bitmap:** 26 bits; cleared only by reset.
- **Bad codes:** never touch `used`, `guess_out`, or the count.
- **Switch changes:** changing `sw_letter` after capture has no effect.

## Timing
- **Reset values:** `guess_out`=6'h00 (dash code, matches no letter), all strobes 0, `guesses_made`=0, `used`=0.
- **Strobe timing:** a strobe is high exactly 2 cycles after the clock edge at which the debounced level falls. The edge moves the FSM to CHECK, the next edge to ISSUE, and the strobe is high during ISSUE.
- **Output update:** `guess_out` and `guesses_made` change at the clock edge that ends the `guess_valid` cycle.
- **Press-to-strobe latency:** from the first low sample at the synchroniser output, the debounced level falls `DEBOUNCE_CYCLES` cycles later, then the strobe follows 2 cycles after that.
- **Bounce:** glitches shorter than `DEBOUNCE_CYCLES` produce nothing.
- **One guess per press:** a second press requires a debounced release first.
- **`game_over` timing:** sampled only in IDLE. Rising in CHECK or ISSUE does not cancel the in-flight guess.
- **Reset mid-operation:** all state is cleared immediately. A key held through reset release produces no guess, because the FSM starts in WAIT_RELEASE.
- **Saturation:** `guesses_made` stays at 26. A full `used` map makes every valid letter a dup.

## Configuration
- **`GUESS_DUP_CHECK_EN` defined:** duplicate detection and the `used` bitmap are present, as above.
- **`GUESS_DUP_CHECK_EN` undefined:**
  - No bitmap.
  - `dup_flag` tied 0.
  - Every in-range letter is accepted with `guess_valid` and increments `guesses_made` (still saturating at 26).

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
- **Single press:** reset, `sw_letter`=6'h1C, clean press held 20 cycles -> `guess_valid` high 1 cycle, exactly 2 cycles after the debounced fall; then `guess_out`=6'h1C, `guesses_made`=1.
- **Bouncy press:** `key_n` toggling every 2 cycles for 12 cycles, then low -> exactly one strobe; `sw_letter` changed to 6'h0A after capture, yet `guess_out` stays 6'h1C.
- **Duplicate:** press 6'h1D twice, releasing between presses -> `guess_valid` then `dup_flag`; `guesses_made`=1. With macro off -> two `guess_valid` strobes and count 2.
- **Out of range:** press with 6'h05 and with 6'h30 -> `bad_flag` each time; `guess_out` and count unchanged.
- **Game over:** `game_over`=1, press 6'h0A -> no strobe; clear `game_over`, release, press again -> `guess_valid`.
- **Reset mid-operation:** assert `resetn`=0 during CHECK while the key is held, then release reset with the key still held -> no strobe; `guess_out`=6'h00; the next full press-release cycle produces a normal strobe.

Source files
------------

// File: rtl/guess_entry.sv
// ---------------------------------------------------------------------------
// guess_entry
//
// Guess-commit stage in front of the hangman control_unit. The raw active-low
// commit key is synchronised and debounced. A debounced press latches the
// letter code on the switches. The latched code is then classified as
// out-of-alphabet (bad), already guessed (dup) or new. Only new letters
// update guess_out and the guess counter, and they are flagged with a
// one-cycle guess_valid strobe.
//
// Optional feature macro: GUESS_DUP_CHECK_EN
//   defined   - a 26-bit "used" bitmap tracks accepted letters, and repeated
//               letters raise dup_flag instead of guess_valid.
//   undefined - there is no bitmap, dup_flag is tied low, and every in-range
//               letter is accepted.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to flip the level
//   LETTER_MIN       code of letter A
//   LETTER_MAX       code of letter Z
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   key_n         raw commit push-button, active-low, asynchronous
//   sw_letter     raw 6-bit letter code from the switches
//   game_over     high in LOSE/WIN; a press seen in IDLE is then ignored
//   guess_out     last accepted letter code (6'h00 after reset)
//   guess_valid   one-cycle strobe, new letter accepted
//   dup_flag      one-cycle strobe, letter already accepted earlier
//   bad_flag      one-cycle strobe, code outside LETTER_MIN..LETTER_MAX
//   guesses_made  number of accepted letters, saturating at 26
// ---------------------------------------------------------------------------
module guess_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [5:0]  LETTER_MIN      = 6'hA,
    parameter logic [5:0]  LETTER_MAX      = 6'h23
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_n,
    input  logic [5:0] sw_letter,
    input  logic       game_over,
    output logic [5:0] guess_out,
    output logic       guess_valid,
    output logic       dup_flag,
    output logic       bad_flag,
    output logic [4:0] guesses_made
);

    localparam int               CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       MAX_GUESSES = 5'd26;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_RELEASE
    } state_t;

    // Synchroniser and debouncer state
    logic             r_sync1;
    logic             r_sync2;
    logic             r_keyLevel;
    logic [CNT_W-1:0] r_cnt;

    // FSM state and registered outputs
    state_t     r_state;
    logic [5:0] r_cap;
    logic [5:0] r_guessOut;
    logic       r_guessValid;
    logic       r_badFlag;
    logic [4:0] r_count;

    logic w_flip;
    logic w_press;
    logic w_capBad;

`ifdef GUESS_DUP_CHECK_EN
    logic [25:0] r_used;
    logic        r_dupFlag;
    logic [4:0]  w_usedIdx;

    // Only meaningful for in-range codes; bad codes never reach the bitmap.
    assign w_usedIdx = 5'(r_cap - LETTER_MIN);
`endif

    // The synchroniser resets to the "pressed" value so that the FSM only
    // leaves WAIT_RELEASE once the real key level has been observed high.
    // Together with the WAIT_RELEASE exit condition this keeps a key that is
    // held through reset release from turning into a guess.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_keyLevel <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_keyLevel) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_keyLevel <= r_sync2;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // The press is decoded from the same condition that flips the debounced
    // level, so the FSM enters CHECK on the very edge where the level falls.
    assign w_flip   = (r_sync2 != r_keyLevel) && (r_cnt == CNT_LAST);
    assign w_press  = w_flip && r_keyLevel;
    assign w_capBad = (r_cap < LETTER_MIN) || (r_cap > LETTER_MAX);

    // Entry FSM. The strobe registers double as the classification result:
    // they are set on the CHECK->ISSUE edge, so they are high for exactly
    // the ISSUE cycle. The ISSUE->WAIT_RELEASE edge then commits a new
    // letter into guess_out, the counter and the bitmap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_WAIT_RELEASE;
            r_cap        <= 6'h00;
            r_guessOut   <= 6'h00;
            r_guessValid <= 1'b0;
            r_badFlag    <= 1'b0;
            r_count      <= 5'd0;
`ifdef GUESS_DUP_CHECK_EN
            r_dupFlag    <= 1'b0;
            r_used       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        if (game_over) begin
                            r_state <= S_WAIT_RELEASE;
                        end else begin
                            r_cap   <= sw_letter;
                            r_state <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (w_capBad) begin
                        r_badFlag <= 1'b1;
                    end
`ifdef GUESS_DUP_CHECK_EN
                    else if (r_used[w_usedIdx]) begin
                        r_dupFlag <= 1'b1;
                    end
`endif
                    else begin
                        r_guessValid <= 1'b1;
                    end
                    r_state <= S_ISSUE;
                end

                S_ISSUE: begin
                    r_guessValid <= 1'b0;
                    r_badFlag    <= 1'b0;
`ifdef GUESS_DUP_CHECK_EN
                    r_dupFlag    <= 1'b0;
`endif
                    if (r_guessValid) begin
                        r_guessOut <= r_cap;
`ifdef GUESS_DUP_CHECK_EN
                        r_used[w_usedIdx] <= 1'b1;
`endif
                        if (r_count != MAX_GUESSES) begin
                            r_count <= r_count + 5'd1;
                        end
                    end
                    r_state <= S_WAIT_RELEASE;
                end

                S_WAIT_RELEASE: begin
                    // Requiring the synchronised sample as well as the
                    // debounced level keeps the FSM here right after reset,
                    // until a genuine released level has reached the sampler.
                    if (r_keyLevel && r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_WAIT_RELEASE;
                end
            endcase
        end
    end

    assign guess_out    = r_guessOut;
    assign guess_valid  = r_guessValid;
    assign bad_flag     = r_badFlag;
    assign guesses_made = r_count;
`ifdef GUESS_DUP_CHECK_EN
    assign dup_flag     = r_dupFlag;
`else
    assign dup_flag     = 1'b0;
`endif

endmodule
